// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32 constants, fetch entry type and alignment helper
package rv32_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0: what decode sees whenever no instruction is presented
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // One buffered fetch result: instruction word tagged with the PC it came from
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Clears the byte-offset bits so every fetch address is word aligned
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// rtl/ifetch_fifo.sv - synchronous FIFO holding {pc, instr} fetch results
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   clear              empties the FIFO; wins over push and pop
//   push, push_data    write one entry (accepted when not full, or when full and popping)
//   pop, pop_data      remove the head; pop_data always shows the head entry
//   count, full, empty occupancy status
module ifetch_fifo
    import rv32_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 2 * XLEN,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // When full, a push is only legal alongside a pop: the head is read
    // combinationally before the edge, so the shared slot is safely reused.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign pop_data = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch stage: PC, credited imem requests, result buffer
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   imem_req_valid/ready/addr          fetch request channel (addr is the PC register)
//   imem_rsp_valid/data                in-order fetch responses
//   redirect_valid, redirect_pc        flush and restart fetch at a new PC
//   ir_valid/ready, ir, ir_pc          instruction handoff to decode
module ifetch_unit
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            ir_valid,
    input  logic            ir_ready,
    output logic [XLEN-1:0] ir,
    output logic [XLEN-1:0] ir_pc
);

    localparam int AW  = $clog2(QDEPTH);
    localparam int CW  = $clog2(QDEPTH + 1);
    localparam int SW  = CW + 1;
    localparam logic [SW-1:0] CREDITS = SW'(QDEPTH);

    logic [XLEN-1:0] pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_next;
    logic [CW-1:0]   drop;

    // Address queue: PCs of requests still waiting for their response
    logic [XLEN-1:0] aq [QDEPTH];
    logic [AW-1:0]   aq_wptr;
    logic [AW-1:0]   aq_rptr;

    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    fetch_entry_t    fifo_in;
    fetch_entry_t    fifo_head;

    logic [SW-1:0]   credit_used;
    logic            can_issue;
    logic            req_fire;
    logic            rsp_keep;
    logic            ir_fire;

    // Every issued request reserves a FIFO slot until its word leaves, so a
    // response can never find the FIFO full.
    assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
    assign can_issue   = (credit_used < CREDITS);

    // Request is forced low while reset is held and during a redirect cycle
    assign imem_req_valid = rst_n & can_issue & ~redirect_valid;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid & imem_req_ready;

    // Responses owed to requests issued before a redirect are consumed but not kept
    assign rsp_keep = imem_rsp_valid & (drop == '0) & ~redirect_valid;
    assign fifo_in  = '{pc: aq[aq_rptr], instr: imem_rsp_data};

    assign ir_valid = ~fifo_empty & ~redirect_valid;
    assign ir_fire  = ir_valid & ir_ready;
    assign ir       = ir_valid ? fifo_head.instr : NOP_INSTR;
    assign ir_pc    = ir_valid ? fifo_head.pc : '0;

    // Requests still owed a response after this cycle; a redirect turns this
    // into the number of responses to discard.
    always_comb begin
        outstanding_next = outstanding;
        if (req_fire && !imem_rsp_valid) begin
            outstanding_next = outstanding + CW'(1);
        end else if (!req_fire && imem_rsp_valid) begin
            outstanding_next = outstanding - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                pc   <= word_align(redirect_pc);
                drop <= outstanding_next;
            end else begin
                if (req_fire) begin
                    pc <= pc + 32'd4;
                end
                if (imem_rsp_valid && (drop != '0)) begin
                    drop <= drop - CW'(1);
                end
            end
        end
    end

    // Address queue stays in step with the response stream across redirects;
    // it is never flushed, only drained by the responses it is waiting for.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            aq[aq_wptr] <= pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aq_wptr <= '0;
            aq_rptr <= '0;
        end else begin
            if (req_fire) begin
                aq_wptr <= aq_wptr + AW'(1);
            end
            if (imem_rsp_valid) begin
                aq_rptr <= aq_rptr + AW'(1);
            end
        end
    end

    ifetch_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (2 * XLEN)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (redirect_valid),
        .push      (rsp_keep),
        .push_data (fifo_in),
        .pop       (ir_fire),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - scoreboard testbench for ifetch_unit
module tb_ifetch_unit;
    import rv32_pkg::*;

    localparam int QDEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir;
    logic [31:0] ir_pc;

    always #5 clk = ~clk;

    ifetch_unit #(
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (QDEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ir_valid       (ir_valid),
        .ir_ready       (ir_ready),
        .ir             (ir),
        .ir_pc          (ir_pc)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem_q[$];
    logic [31:0] fire_log[$];
    logic [31:0] ir_log[$];
    logic [31:0] exp_addr;
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          fires = 0;
    int          first_fire_cyc = -1;
    int          first_irv_cyc = -1;
    bit          mem_hold = 0;
    bit          mem_slow = 0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, imem_req_valid, 1'b0);
        chk({tag, "_req_addr"}, imem_req_addr, 32'h0);
        chk({tag, "_ir_valid"}, ir_valid, 1'b0);
        chk({tag, "_ir"}, ir, NOP_INSTR);
        chk({tag, "_ir_pc"}, ir_pc, 32'h0);
    endtask

    // Asserts reset at the current point in the cycle, checks outputs
    // immediately, then releases on a falling edge with the model cleared.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs(tag);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        mem_q.delete();
        fire_log.delete();
        ir_log.delete();
        exp_addr       = 32'h0;
        mem_hold       = 1'b0;
        mem_slow       = 1'b0;
        fires          = 0;
        first_fire_cyc = -1;
        first_irv_cyc  = -1;
        cyc            = 0;
        rst_n          = 1'b1;
    endtask

    // One clock cycle, entered and left on a falling edge. The memory model
    // answers in order, no earlier than the cycle after a request fires.
    task automatic cycle(input bit rd_busy, input logic [31:0] rd_target, output bit hit);
        bit rsp_pop;
        bit rfire;
        bit ifire;
        hit     = 1'b0;
        rsp_pop = (mem_q.size() > 0) && !mem_hold && (!mem_slow || ($urandom_range(0, 1) == 1));
        imem_rsp_valid = rsp_pop;
        imem_rsp_data  = rsp_pop ? word_of(mem_q[0]) : 32'h0;
        #1;
        if (rd_busy && ir_valid && imem_rsp_valid) begin
            redirect_valid = 1'b1;
            redirect_pc    = rd_target;
            hit            = 1'b1;
            #1;
        end
        rfire = imem_req_valid && imem_req_ready;
        ifire = ir_valid && ir_ready;

        if (imem_req_valid) chk("req_addr", imem_req_addr, exp_addr);
        if (redirect_valid) begin
            chk("req_valid_in_redirect", imem_req_valid, 1'b0);
            chk("ir_valid_in_redirect", ir_valid, 1'b0);
        end
        if (!ir_valid) begin
            chk("idle_ir", ir, NOP_INSTR);
            chk("idle_ir_pc", ir_pc, 32'h0);
        end
        if (imem_rsp_valid) chk("rsp_into_full_fifo", dut.u_fifo.full, 1'b0);
        if (ir_valid && first_irv_cyc < 0) first_irv_cyc = cyc;

        if (ifire) begin
            if (exp_q.size() == 0) begin
                chk("ir_unexpected_pc", ir_pc, 32'hDEAD_BEEF);
            end else begin
                exp_t e = exp_q.pop_front();
                chk("ir_pc", ir_pc, e.pc);
                chk("ir_word", ir, e.word);
            end
            ir_log.push_back(ir_pc);
        end

        if (rsp_pop) void'(mem_q.pop_front());
        // Everything fetched before a redirect must be thrown away
        if (redirect_valid) begin
            exp_q.delete();
            exp_addr = redirect_pc & ~32'h3;
        end
        if (rfire) begin
            mem_q.push_back(imem_req_addr);
            exp_q.push_back('{exp_addr, word_of(exp_addr)});
            fire_log.push_back(imem_req_addr);
            exp_addr = exp_addr + 32'd4;
            fires++;
            if (first_fire_cyc < 0) first_fire_cyc = cyc;
        end

        @(negedge clk);
        cyc++;
        redirect_valid = 1'b0;
    endtask

    task automatic run(input int n);
        bit h;
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, h);
    endtask

    function automatic logic [31:0] log_at(input logic [31:0] q[$], input int idx);
        return (q.size() > idx) ? q[idx] : 32'hDEAD_DEAD;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit hit;
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        ir_ready       = 1'b1;
        @(negedge clk);

        // Streaming from reset
        do_reset("rst0");
        run(12);
        chk("first_ir_latency", 32'(first_irv_cyc - first_fire_cyc), 32'd2);
        chk("stream_pc0", log_at(ir_log, 0), 32'h0);
        chk("stream_pc1", log_at(ir_log, 1), 32'h4);
        chk("stream_pc2", log_at(ir_log, 2), 32'h8);
        chk("stream_pc3", log_at(ir_log, 3), 32'hC);

        // Decode stalled: credits cap fetch at QDEPTH
        do_reset("rst1");
        ir_ready = 1'b0;
        run(10);
        chk("stall_fires", fires, QDEPTH);
        #1;
        chk("stall_req_valid", imem_req_valid, 1'b0);
        fire_log.delete();
        ir_log.delete();
        ir_ready = 1'b1;
        run(8);
        chk("drain_pc0", log_at(ir_log, 0), 32'h0);
        chk("drain_pc1", log_at(ir_log, 1), 32'h4);
        chk("resume_addr", log_at(fire_log, 0), 32'h8);

        // Redirect with two requests in flight
        do_reset("rst2");
        mem_hold = 1'b1;
        run(3);
        chk("inflight_fires", fires, 2);
        fire_log.delete();
        ir_log.delete();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        run(1);
        mem_hold = 1'b0;
        run(10);
        chk("redirect_first_addr", log_at(fire_log, 0), 32'h100);
        chk("redirect_first_ir_pc", log_at(ir_log, 0), 32'h100);

        // Redirect colliding with a response while the FIFO holds a word
        do_reset("rst3");
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) cycle(1'b1, 32'h0000_0200, hit);
        chk("collide_found", hit, 1'b1);
        #1;
        chk("collide_fifo_empty", ir_valid, 1'b0);
        ir_log.delete();
        run(10);
        chk("collide_first_ir_pc", log_at(ir_log, 0), 32'h200);

        // PC wrap at the top of the address space
        fire_log.delete();
        ir_log.delete();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        run(12);
        chk("wrap_addr0", log_at(fire_log, 0), 32'hFFFF_FFFC);
        chk("wrap_addr1", log_at(fire_log, 1), 32'h0000_0000);
        chk("wrap_ir_pc0", log_at(ir_log, 0), 32'hFFFF_FFFC);
        chk("wrap_ir_pc1", log_at(ir_log, 1), 32'h0000_0000);

        // Randomised traffic: memory latency, decode backpressure, redirects
        mem_slow = 1'b1;
        for (int i = 0; i < 400; i++) begin
            ir_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 24) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom();
            end
            run(1);
        end
        mem_slow = 1'b0;
        ir_ready = 1'b1;

        // Reset asserted in the middle of a response
        run(4);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1234_5678;
        #1;
        do_reset("rst_mid");
        fire_log.delete();
        run(6);
        chk("post_reset_addr", log_at(fire_log, 0), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
